fetch_prefetch_unit: RTL and testbench

- Parametrised successor to the single-word program-memory fetch stage.
- Drives a 1-cycle synchronous-read instruction memory and buffers returned words in a small prefetch FIFO.
- Hands instructions to decode over a valid/ready handshake; decode stalls are absorbed without re-fetching.
- Jump redirects flush the FIFO and squash in-flight reads.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_prefetch_unit_sync_fifo.sv | 58 +++++
 rtl/fetch_prefetch_unit.sv | 87 ++++++++
 tb/tb_fetch_prefetch_unit.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared defaults and the prefetch entry layout for the fetch stage.
package fetch_pkg;

  localparam int unsigned ADDR_W_DEF   = 16;
  localparam int unsigned INS_W_DEF    = 32;
  localparam int unsigned RESET_PC_DEF = 0;

  // One buffered instruction together with the address it was fetched from.
  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [INS_W_DEF-1:0]  ins;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_prefetch_unit_sync_fifo.sv
// Small synchronous FIFO with flush; head is read combinationally from storage.
module sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 48
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic [W-1:0]             head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_pop_c;

  // Popping an empty FIFO is ignored.
  always_comb begin
    do_pop_c = pop & (cnt != '0);
  end

  // Pointer and occupancy tracking; flush returns to the empty state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push)     wr_ptr <= wr_ptr + 1'b1;
      if (do_pop_c) rd_ptr <= rd_ptr + 1'b1;
      if (push && !do_pop_c)      cnt <= cnt + 1'b1;
      else if (!push && do_pop_c) cnt <= cnt - 1'b1;
    end
  end

  // Entry storage; contents are only meaningful while counted.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

  assign head  = mem[rd_ptr];
  assign count = cnt;
  assign empty = (cnt == '0);

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Fetch stage: issues reads to a 1-cycle memory, buffers returns, hands them to decode.
module fetch_prefetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned INS_W    = INS_W_DEF,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned RESET_PC = RESET_PC_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              jmp_en,
  input  logic [ADDR_W-1:0] jmp_loc,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [INS_W-1:0]  mem_rdata,
  output logic              ins_valid,
  input  logic              ins_ready,
  output logic [INS_W-1:0]  ins,
  output logic [ADDR_W-1:0] ins_addr
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned OCC_W = CNT_W + 1;
  localparam int unsigned ENT_W = ADDR_W + INS_W;

  logic [ADDR_W-1:0] pc;
  logic              inflight;
  logic [ADDR_W-1:0] inflight_addr;

  logic [CNT_W-1:0]  count;
  logic              empty;
  logic [ENT_W-1:0]  head;

  logic [OCC_W-1:0]  occ_c;
  logic              issue_c;
  logic              push_c;
  logic              pop_c;

  // Issue/return/hand-off decisions; a redirect overrides occupancy and blocks transfer.
  always_comb begin
    occ_c     = {1'b0, count} + OCC_W'(inflight);
    issue_c   = jmp_en | (occ_c < OCC_W'(DEPTH));
    push_c    = inflight & ~jmp_en;
    ins_valid = ~empty & ~jmp_en;
    pop_c     = ins_valid & ins_ready;
    mem_req   = reset & issue_c;
    mem_addr  = (reset & jmp_en) ? jmp_loc : pc;
    ins       = ins_valid ? head[INS_W-1:0] : '0;
    ins_addr  = ins_valid ? head[ENT_W-1:INS_W] : '0;
  end

  // PC and in-flight read tracking; a redirect replaces any outstanding read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc            <= ADDR_W'(RESET_PC);
      inflight      <= 1'b0;
      inflight_addr <= '0;
    end else if (jmp_en) begin
      pc            <= jmp_loc + 1'b1;
      inflight      <= 1'b1;
      inflight_addr <= jmp_loc;
    end else begin
      inflight <= issue_c;
      if (issue_c) begin
        pc            <= pc + 1'b1;
        inflight_addr <= pc;
      end
    end
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .W     (ENT_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_c),
    .wdata ({inflight_addr, mem_rdata}),
    .pop   (pop_c),
    .flush (jmp_en),
    .count (count),
    .empty (empty),
    .head  (head)
  );

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Bench for fetch_prefetch_unit: queue-based model of outstanding fetches.
module tb_fetch_prefetch_unit;
  import fetch_pkg::*;

  localparam int DEPTH = 4;
  localparam logic [15:0] RST_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        jmp_en;
  logic [15:0] jmp_loc;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        ins_valid;
  logic        ins_ready;
  logic [31:0] ins;
  logic [15:0] ins_addr;

  int vectors = 0;
  int miscompares = 0;

  // Model: every requested word since the last redirect/reset, oldest first.
  fetch_entry_t q[$];
  logic [15:0]  fpc;
  logic         infl;

  fetch_prefetch_unit #(.ADDR_W(16), .INS_W(32), .DEPTH(DEPTH), .RESET_PC(0)) dut (
    .clk       (clk),
    .reset     (reset),
    .jmp_en    (jmp_en),
    .jmp_loc   (jmp_loc),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .ins_valid (ins_valid),
    .ins_ready (ins_ready),
    .ins       (ins),
    .ins_addr  (ins_addr)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory; garbage when not requested.
  always @(posedge clk)
    mem_rdata <= mem_req ? (32'hA000_0000 | {16'h0, mem_addr}) : 32'hDEAD_BEEF;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic fetch_entry_t mk(input logic [15:0] a);
    fetch_entry_t e;
    e.addr = a;
    e.ins  = 32'hA000_0000 | {16'h0, a};
    return e;
  endfunction

  task automatic model_reset();
    q.delete();
    fpc  = RST_PC;
    infl = 1'b0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'(RST_PC));
    chk("rst_ins_valid", 32'(ins_valid), 32'd0);
    chk("rst_ins", ins, 32'd0);
    chk("rst_ins_addr", 32'(ins_addr), 32'd0);
  endtask

  // One clock: drive at negedge, check outputs, advance model to the next edge.
  task automatic cycle(input logic j, input logic [15:0] loc, input logic r);
    logic         exp_req;
    logic         exp_valid;
    int           avail;
    fetch_entry_t hd;
    fetch_entry_t dummy;
    @(negedge clk);
    jmp_en = j; jmp_loc = loc; ins_ready = r;
    #1;
    exp_req   = j || (q.size() < DEPTH);
    avail     = q.size() - (infl ? 1 : 0);
    exp_valid = !j && (avail > 0);
    chk("mem_req", 32'(mem_req), 32'(exp_req));
    if (exp_req) chk("mem_addr", 32'(mem_addr), 32'(j ? loc : fpc));
    chk("ins_valid", 32'(ins_valid), 32'(exp_valid));
    if (exp_valid) begin
      hd = q[0];
      chk("ins_addr", 32'(ins_addr), 32'(hd.addr));
      chk("ins", ins, hd.ins);
    end else begin
      chk("ins_idle", ins, 32'd0);
      chk("ins_addr_idle", 32'(ins_addr), 32'd0);
    end
    if (j) begin
      q.delete();
      q.push_back(mk(loc));
      fpc  = loc + 16'd1;
      infl = 1'b1;
    end else begin
      if (exp_valid && r) dummy = q.pop_front();
      if (exp_req) begin
        q.push_back(mk(fpc));
        fpc = fpc + 16'd1;
      end
      infl = exp_req;
    end
  endtask

  task automatic run(input int n, input logic r);
    for (int i = 0; i < n; i++) cycle(1'b0, 16'h0, r);
  endtask

  initial begin
    reset = 1'b0; jmp_en = 1'b0; jmp_loc = '0; ins_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs();
    @(posedge clk); #1 reset = 1'b1;

    // Streaming from reset, then a 10-cycle stall and resume.
    run(3, 1'b1);
    run(10, 1'b0);
    run(8, 1'b1);

    // Redirect while words are buffered and a read is in flight.
    run(2, 1'b0);
    cycle(1'b1, 16'h0040, 1'b1);
    run(6, 1'b1);

    // Back-to-back redirects: only the last target is delivered.
    cycle(1'b1, 16'h0100, 1'b1);
    cycle(1'b1, 16'h0200, 1'b1);
    run(6, 1'b1);

    // Address wrap at the top of the space.
    cycle(1'b1, 16'hFFFE, 1'b1);
    run(7, 1'b1);

    // Asynchronous reset mid-stream with a full FIFO.
    run(8, 1'b0);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk_reset_outputs();
    model_reset();
    @(posedge clk); #1;
    chk_reset_outputs();
    @(posedge clk); #1 reset = 1'b1;
    run(6, 1'b1);

    // Randomized ready/redirect traffic.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 15) == 0), 16'($urandom), ($urandom_range(0, 3) != 0));
    end
    run(12, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
